// File: rtl/vc_link_if.sv
// Bus bundle between the VC input buffers, the link register and the scheduler.
interface vc_link_if #(
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned FLIT_W = 8,
    parameter int unsigned VC_W   = 2
);
    logic [NUM_VC-1:0]        vc_empty_i;
    logic [NUM_VC*FLIT_W-1:0] vc_fdata_i;
    logic [NUM_VC-1:0]        vc_read_o;
    logic [NUM_VC-1:0]        credit_return_i;
    logic                     link_valid_o;
    logic [VC_W-1:0]          link_vc_o;
    logic [FLIT_W-1:0]        link_fdata_o;
    logic                     locked_o;
    logic                     proto_err_o;
    logic                     credit_err_o;

    // Scheduler side.
    modport master (
        input  vc_empty_i, vc_fdata_i, credit_return_i,
        output vc_read_o, link_valid_o, link_vc_o, link_fdata_o,
               locked_o, proto_err_o, credit_err_o
    );

    // Buffer / link / downstream side.
    modport slave (
        output vc_empty_i, vc_fdata_i, credit_return_i,
        input  vc_read_o, link_valid_o, link_vc_o, link_fdata_o,
               locked_o, proto_err_o, credit_err_o
    );
endinterface

// File: rtl/vc_link_scheduler.sv
// Wormhole link scheduler: round-robin head arbitration among VC FIFOs,
// link locked to the winning VC until its tail, per-VC downstream credits.
module vc_link_scheduler #(
    parameter int unsigned NUM_VC      = 4,
    parameter int unsigned FLIT_W      = 8,
    parameter int unsigned MAX_CREDITS = 2,
    parameter int unsigned CREDIT_W    = 2,
    parameter int unsigned VC_W        = 2
) (
    input  logic       clk,
    input  logic       arst,
    vc_link_if.master  bus
);
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b01;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nxt;
    logic [VC_W-1:0]       rr_ptr, rr_nxt;
    logic [VC_W-1:0]       lock_vc, lock_nxt;
    logic [CREDIT_W-1:0]   credit     [NUM_VC];
    logic [CREDIT_W-1:0]   credit_nxt [NUM_VC];
    logic [1:0]            ftype      [NUM_VC];
    logic [NUM_VC-1:0]     can_send, drop_req, pop, send, ovf;
    logic                  found;
    logic [VC_W-1:0]       idx;
    logic [VC_W-1:0]       send_vc;
    logic                  proto_nxt;
    logic                  link_valid_q, proto_err_q, credit_err_q;
    logic [VC_W-1:0]       link_vc_q;
    logic [FLIT_W-1:0]     link_fdata_q;

    // Per-VC flit type, send eligibility and stray body/tail detection.
    always_comb begin
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            ftype[k]    = bus.vc_fdata_i[k*FLIT_W + FLIT_W - 2 +: 2];
            can_send[k] = !bus.vc_empty_i[k] && (credit[k] != '0);
            drop_req[k] = !bus.vc_empty_i[k] && !ftype[k][1];
        end
    end

    // Next-state, grant and pop logic.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        lock_nxt  = lock_vc;
        pop       = '0;
        send      = '0;
        send_vc   = lock_vc;
        proto_nxt = 1'b0;
        found     = 1'b0;
        idx       = '0;
        case (state)
            IDLE: begin
                if (|drop_req) begin
                    // Drop the lowest-indexed stray non-head flit; no grant this cycle.
                    for (int unsigned k = 0; k < NUM_VC; k++) begin
                        if (drop_req[k] && !found) begin
                            found  = 1'b1;
                            pop[k] = 1'b1;
                        end
                    end
                    proto_nxt = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < NUM_VC; i++) begin
                        idx = VC_W'((32'(rr_ptr) + i) % NUM_VC);
                        if (!found && can_send[idx] && ftype[idx][1]) begin
                            found     = 1'b1;
                            pop[idx]  = 1'b1;
                            send[idx] = 1'b1;
                            send_vc   = idx;
                            if (ftype[idx] == T_HEAD) begin
                                state_nxt = LOCKED;
                                lock_nxt  = idx;
                            end else begin
                                rr_nxt = VC_W'((32'(idx) + 1) % NUM_VC);
                            end
                        end
                    end
                end
            end
            LOCKED: begin
                if (can_send[lock_vc]) begin
                    pop[lock_vc]  = 1'b1;
                    send[lock_vc] = 1'b1;
                    if (ftype[lock_vc] == T_TAIL) begin
                        state_nxt = IDLE;
                        rr_nxt    = VC_W'((32'(lock_vc) + 1) % NUM_VC);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!arst) begin
            pop  = '0;
            send = '0;
        end
    end

    // Credit bookkeeping: -1 on send, +1 on return, saturate and flag overflow.
    always_comb begin
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            credit_nxt[k] = credit[k];
            ovf[k]        = 1'b0;
            case ({send[k], bus.credit_return_i[k]})
                2'b10: credit_nxt[k] = credit[k] - CREDIT_W'(1);
                2'b01: begin
                    if (credit[k] == CREDIT_W'(MAX_CREDITS)) ovf[k] = 1'b1;
                    else credit_nxt[k] = credit[k] + CREDIT_W'(1);
                end
                default: credit_nxt[k] = credit[k];
            endcase
        end
    end

    // State, arbitration pointer and credit registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_vc <= '0;
            for (int unsigned k = 0; k < NUM_VC; k++) credit[k] <= CREDIT_W'(MAX_CREDITS);
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_nxt;
            lock_vc <= lock_nxt;
            for (int unsigned k = 0; k < NUM_VC; k++) credit[k] <= credit_nxt[k];
        end
    end

    // Link register and error pulses; link data holds when nothing is sent.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            link_valid_q <= 1'b0;
            link_vc_q    <= '0;
            link_fdata_q <= '0;
            proto_err_q  <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            link_valid_q <= |send;
            if (|send) begin
                link_vc_q    <= send_vc;
                link_fdata_q <= bus.vc_fdata_i[send_vc*FLIT_W +: FLIT_W];
            end
            proto_err_q  <= proto_nxt;
            credit_err_q <= |ovf;
        end
    end

    assign bus.vc_read_o    = pop;
    assign bus.locked_o     = (state == LOCKED);
    assign bus.link_valid_o = link_valid_q;
    assign bus.link_vc_o    = link_vc_q;
    assign bus.link_fdata_o = link_fdata_q;
    assign bus.proto_err_o  = proto_err_q;
    assign bus.credit_err_o = credit_err_q;
endmodule

// File: tb/tb_vc_link_scheduler.sv
// Directed bench for vc_link_scheduler: FIFO heads driven by hand each cycle.
module tb_vc_link_scheduler;
    logic clk;
    logic arst;
    int   n_chk;
    int   n_fail;

    vc_link_if #(.NUM_VC(4), .FLIT_W(8), .VC_W(2)) bus ();

    vc_link_scheduler #(
        .NUM_VC(4), .FLIT_W(8), .MAX_CREDITS(2), .CREDIT_W(2), .VC_W(2)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input int k, input logic [7:0] d);
        bus.vc_empty_i[k]        = 1'b0;
        bus.vc_fdata_i[k*8 +: 8] = d;
    endtask

    task automatic clr(input int k);
        bus.vc_empty_i[k]        = 1'b1;
        bus.vc_fdata_i[k*8 +: 8] = 8'h00;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        arst   = 1'b0;
        bus.vc_empty_i      = 4'b1111;
        bus.vc_fdata_i      = '0;
        bus.credit_return_i = 4'b0000;

        // Reset values
        cyc(); cyc();
        chk("rst_valid",  32'(bus.link_valid_o), 32'd0);
        chk("rst_vc",     32'(bus.link_vc_o),    32'd0);
        chk("rst_data",   32'(bus.link_fdata_o), 32'd0);
        chk("rst_locked", 32'(bus.locked_o),     32'd0);
        chk("rst_perr",   32'(bus.proto_err_o),  32'd0);
        chk("rst_cerr",   32'(bus.credit_err_o), 32'd0);
        put(1, 8'hC5); settle();
        chk("rst_read_gated", 32'(bus.vc_read_o), 32'h0);

        // Single flit on VC1
        arst = 1'b1; settle();
        chk("t1_read", 32'(bus.vc_read_o), 32'b0010);
        cyc(); clr(1); bus.credit_return_i = 4'b0010; settle();
        chk("t1_valid", 32'(bus.link_valid_o), 32'd1);
        chk("t1_vc",    32'(bus.link_vc_o),    32'd1);
        chk("t1_data",  32'(bus.link_fdata_o), 32'hC5);
        chk("t1_read0", 32'(bus.vc_read_o),    32'h0);
        cyc(); bus.credit_return_i = 4'b0000; settle();
        chk("t1_idle_valid", 32'(bus.link_valid_o), 32'd0);
        chk("t1_hold_data",  32'(bus.link_fdata_o), 32'hC5);
        chk("t1_no_cerr",    32'(bus.credit_err_o), 32'd0);

        // VC0 packet head/body/tail, VC2 head waits then wins after the tail
        put(0, 8'h81); bus.credit_return_i = 4'b0001; settle();
        chk("t2_read_head", 32'(bus.vc_read_o), 32'b0001);
        cyc(); put(0, 8'h02); put(2, 8'h84); settle();
        chk("t2_vc_a",     32'(bus.link_vc_o),    32'd0);
        chk("t2_data_a",   32'(bus.link_fdata_o), 32'h81);
        chk("t2_locked",   32'(bus.locked_o),     32'd1);
        chk("t2_read_body",32'(bus.vc_read_o),    32'b0001);
        cyc(); put(0, 8'h43); settle();
        chk("t2_vc_b",     32'(bus.link_vc_o),    32'd0);
        chk("t2_data_b",   32'(bus.link_fdata_o), 32'h02);
        chk("t2_read_tail",32'(bus.vc_read_o),    32'b0001);
        cyc(); clr(0); bus.credit_return_i = 4'b0100; settle();
        chk("t2_vc_c",     32'(bus.link_vc_o),    32'd0);
        chk("t2_data_c",   32'(bus.link_fdata_o), 32'h43);
        chk("t2_unlocked", 32'(bus.locked_o),     32'd0);
        chk("t2_read_vc2", 32'(bus.vc_read_o),    32'b0100);
        cyc(); put(2, 8'h45); settle();
        chk("t2_vc_d",     32'(bus.link_vc_o),    32'd2);
        chk("t2_data_d",   32'(bus.link_fdata_o), 32'h84);
        chk("t2_locked2",  32'(bus.locked_o),     32'd1);
        cyc(); clr(2); bus.credit_return_i = 4'b0000; settle();
        chk("t2_data_e",   32'(bus.link_fdata_o), 32'h45);
        chk("t2_unlock2",  32'(bus.locked_o),     32'd0);

        // VC3 locked: two credits, stall, one return buys exactly one flit
        put(3, 8'h83); settle();
        chk("t3_read_head", 32'(bus.vc_read_o), 32'b1000);
        cyc(); put(3, 8'h03); settle();
        chk("t3_data_a",  32'(bus.link_fdata_o), 32'h83);
        chk("t3_vc_a",    32'(bus.link_vc_o),    32'd3);
        chk("t3_read_b",  32'(bus.vc_read_o),    32'b1000);
        cyc(); put(3, 8'h04); settle();
        chk("t3_data_b",  32'(bus.link_fdata_o), 32'h03);
        chk("t3_stall_read", 32'(bus.vc_read_o), 32'h0);
        cyc(); bus.credit_return_i = 4'b1000; settle();
        chk("t3_stall_valid", 32'(bus.link_valid_o), 32'd0);
        chk("t3_stall_hold",  32'(bus.link_fdata_o), 32'h03);
        chk("t3_stall_lock",  32'(bus.locked_o),     32'd1);
        chk("t3_ret_same_cycle", 32'(bus.vc_read_o), 32'h0);
        cyc(); bus.credit_return_i = 4'b0000; settle();
        chk("t3_read_after_ret", 32'(bus.vc_read_o), 32'b1000);
        cyc(); put(3, 8'h45); settle();
        chk("t3_data_c",  32'(bus.link_fdata_o), 32'h04);
        chk("t3_valid_c", 32'(bus.link_valid_o), 32'd1);
        chk("t3_read_none", 32'(bus.vc_read_o),  32'h0);
        cyc(); bus.credit_return_i = 4'b1000; settle();
        chk("t3_valid_none", 32'(bus.link_valid_o), 32'd0);
        cyc(); bus.credit_return_i = 4'b0000; settle();
        chk("t3_read_tail", 32'(bus.vc_read_o), 32'b1000);
        cyc(); clr(3); bus.credit_return_i = 4'b1000; settle();
        chk("t3_data_tail", 32'(bus.link_fdata_o), 32'h45);
        chk("t3_unlocked",  32'(bus.locked_o),     32'd0);
        cyc(); cyc(); bus.credit_return_i = 4'b0000; settle();

        // Round robin among four single-flit VCs
        for (int k = 0; k < 4; k++) put(k, 8'(8'hC0 + k));
        for (int i = 0; i < 5; i++) begin
            bus.credit_return_i = 4'(1 << (i % 4));
            settle();
            chk("t4_read", 32'(bus.vc_read_o), 32'(1 << (i % 4)));
            cyc();
            chk("t4_vc",   32'(bus.link_vc_o),    32'(i % 4));
            chk("t4_data", 32'(bus.link_fdata_o), 32'hC0 + 32'(i % 4));
            chk("t4_cerr", 32'(bus.credit_err_o), 32'd0);
        end
        for (int k = 0; k < 4; k++) clr(k);
        bus.credit_return_i = 4'b0000;

        // Stray body flit in IDLE is dropped
        put(2, 8'h11); settle();
        chk("t5_read_drop", 32'(bus.vc_read_o), 32'b0100);
        cyc(); clr(2); settle();
        chk("t5_valid", 32'(bus.link_valid_o), 32'd0);
        chk("t5_perr",  32'(bus.proto_err_o),  32'd1);
        chk("t5_hold",  32'(bus.link_fdata_o), 32'hC0);
        cyc();
        chk("t5_perr_pulse", 32'(bus.proto_err_o), 32'd0);

        // Credit overflow on VC0 saturates at 2
        bus.credit_return_i = 4'b0001; settle();
        cyc(); bus.credit_return_i = 4'b0000; settle();
        chk("t6_cerr", 32'(bus.credit_err_o), 32'd1);
        cyc();
        chk("t6_cerr_pulse", 32'(bus.credit_err_o), 32'd0);
        put(0, 8'hC0); settle();
        chk("t6_send1", 32'(bus.vc_read_o), 32'b0001);
        cyc(); settle();
        chk("t6_send2", 32'(bus.vc_read_o), 32'b0001);
        cyc(); settle();
        chk("t6_blocked", 32'(bus.vc_read_o),    32'h0);
        chk("t6_valid",   32'(bus.link_valid_o), 32'd1);
        clr(0);

        // Reset mid-packet
        put(1, 8'h81); settle();
        chk("t7_read", 32'(bus.vc_read_o), 32'b0010);
        cyc(); put(1, 8'h02); settle();
        chk("t7_locked", 32'(bus.locked_o),     32'd1);
        chk("t7_valid",  32'(bus.link_valid_o), 32'd1);
        #1 arst = 1'b0;
        #1;
        chk("t7_rst_valid",  32'(bus.link_valid_o), 32'd0);
        chk("t7_rst_vc",     32'(bus.link_vc_o),    32'd0);
        chk("t7_rst_data",   32'(bus.link_fdata_o), 32'd0);
        chk("t7_rst_locked", 32'(bus.locked_o),     32'd0);
        chk("t7_rst_read",   32'(bus.vc_read_o),    32'h0);
        clr(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_link_scheduler.md
Name: vc_link_scheduler

Overview:
- Shares one router output link between NUM_VC virtual-channel flit FIFOs: 2-entry, 8-bit, with a combinational head-of-queue `fdata_o`, `empty` flag and a read strobe that pops on the clock edge.
- Wormhole switching: round-robin arbitration among head flits, then the link stays locked to the winning VC until its tail flit is sent.
- Per-VC credit counters track free slots in the downstream router's matching FIFO.
- Sits between the input VC buffers and the link register feeding the neighbouring router.

Parameters:
- NUM_VC, 4, number of virtual channels sharing the link.
- FLIT_W, 8, flit width; bits [FLIT_W-1:FLIT_W-2] carry the flit type.
- MAX_CREDITS, 2, downstream buffer depth per VC; equals credit counter reset value.
- CREDIT_W, 2, credit counter width; must hold MAX_CREDITS.
- VC_W, 2, VC index width, equal to clog2(NUM_VC).

Ports:
- clk  input  1  rising-edge clock.
- arst  input  1  asynchronous active-low reset.
- vc_empty_i  input  NUM_VC  per-VC FIFO empty flags.
- vc_fdata_i  input  NUM_VC*FLIT_W  per-VC head-of-queue flits; VC k occupies bits [k*FLIT_W +: FLIT_W].
- vc_read_o  output  NUM_VC  one-hot pop strobe to the VC FIFOs (combinational).
- credit_return_i  input  NUM_VC  one-cycle pulse per VC: downstream freed one slot.
- link_valid_o  output  1  registered; flit present on the link this cycle.
- link_vc_o  output  VC_W  registered VC tag of the link flit.
- link_fdata_o  output  FLIT_W  registered link flit.
- locked_o  output  1  high while in LOCKED.
- proto_err_o  output  1  registered one-cycle pulse: non-head flit dropped in IDLE.
- credit_err_o  output  1  registered one-cycle pulse: credit overflow.

Behaviour:
- Flit types: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail).
- Reset (arst=0, asynchronous):
  - state=IDLE, rr_ptr=0, lock_vc=0.
  - all credits=MAX_CREDITS.
  - link_valid_o=0, link_vc_o=0, link_fdata_o=0, proto_err_o=0, credit_err_o=0.
  - vc_read_o=0 while arst=0.
- Reset mid-packet drops the lock. Downstream must be reset together.
- Send condition for VC k: vc_empty_i[k]=0 and credit[k]>0.
- IDLE state:
  - Eligible VCs satisfy the send condition and hold a head or single flit.
  - Grant goes to the first eligible VC searching rr_ptr, rr_ptr+1, … modulo NUM_VC.
  - On grant: vc_read_o[k]=1 in the same cycle.
  - Head grant: state→LOCKED, lock_vc=k.
  - Single grant: stay IDLE, rr_ptr=k+1 mod NUM_VC.
  - Before arbitration, any non-empty VC fronting a body or tail flit is popped without sending and raises proto_err_o next cycle. This uses the lowest such index, one per cycle, and blocks the grant that cycle.
- LOCKED state:
  - Only lock_vc is considered; all other VCs wait.
  - Pop and send whenever the send condition holds, at most one flit per cycle.
  - If the sent flit is a tail: state→IDLE, rr_ptr=lock_vc+1 mod NUM_VC.
  - If the sent flit is a head or single: sent as-is, no protocol check in LOCKED.
  - No credit or empty FIFO: stall with no pop and no link_valid_o.
- Latency: the flit popped in cycle N appears on link_fdata_o/link_vc_o with link_valid_o=1 in cycle N+1.
  - link_valid_o=0 in cycles with no send.
  - link_fdata_o/link_vc_o hold their last value when not valid.
- Credits, per VC, per cycle:
  - −1 on send, +1 on credit_return_i.
  - Both together: unchanged.
  - Return at MAX_CREDITS with no send: counter saturates, credit_err_o pulses.
  - credit=0 blocks sending; the returned credit is usable the cycle after the return pulse.
- Throughput: one flit per cycle back-to-back while a VC has credits and data.
  - IDLE→LOCKED adds no bubble: the head is sent in the grant cycle and the next body can go in the next cycle.
- locked_o = (state==LOCKED).

Test Plan:
- Reset, then VC1 fronts single flit 8'hC5 with credit 2 → cycle N: vc_read_o=4'b0010; cycle N+1: link_valid_o=1, link_vc_o=1, link_fdata_o=8'hC5; credit[1]=1; rr_ptr=2.
- VC0 sends head 8'h81, body 8'h02, tail 8'h43 while VC2 holds head 8'h84 → VC0 flits on three consecutive link cycles; VC2 head granted the cycle after the tail pops; link_vc_o sequence 0,0,0,2.
- VC3 in LOCKED with credit 2 and no credit_return_i → two flits sent, then stall with vc_read_o=0 and link_valid_o=0. One credit_return_i[3] pulse → exactly one further flit sent.
- VC0..VC3 all front single flits continuously with credits refreshed → grant order 0,1,2,3,0; each VC granted once per 4 cycles.
- VC2 fronts body flit 8'h11 in IDLE → popped, no link_valid_o, proto_err_o=1 for one cycle.
- credit_return_i[0] pulsed at credit 2 with no send → credit_err_o pulse and credit stays 2.
- arst asserted mid-packet → all outputs reset immediately; locked_o=0.
